// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data RAM.
// Grants are same-cycle; read responses return to their issuer one cycle later.
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m0_gnt,
    output logic                  m1_gnt,
    output logic                  m0_rvalid,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  ram_rd_ena,
    output logic                  ram_wr_ena,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [CNT_WIDTH-1:0]  conflict_cnt
);

    logic                 ready_r;
    logic                 last_r;
    logic                 rd_pend_r;
    logic                 rd_port_r;
    logic [CNT_WIDTH-1:0] conflict_cnt_r;

    logic                 gnt0_s;
    logic                 gnt1_s;
    logic                 we_s;
    logic                 both_req_s;

    assign both_req_s = m0_req & m1_req;

    // Round-robin grant: under contention the port that was not granted last wins.
    always_comb begin
        if (ready_r) begin
            gnt0_s = m0_req & (~m1_req | last_r);
            gnt1_s = m1_req & (~m0_req | ~last_r);
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // RAM-side mux from the granted port; idle bus is driven to zero.
    always_comb begin
        case ({gnt1_s, gnt0_s})
            2'b01: begin
                we_s        = m0_we;
                ram_address = m0_addr;
                ram_wr_data = m0_wdata;
            end
            2'b10: begin
                we_s        = m1_we;
                ram_address = m1_addr;
                ram_wr_data = m1_wdata;
            end
            default: begin
                we_s        = 1'b0;
                ram_address = {ADDR_WIDTH{1'b0}};
                ram_wr_data = {DATA_WIDTH{1'b0}};
            end
        endcase
    end

    assign m0_gnt     = gnt0_s;
    assign m1_gnt     = gnt1_s;
    assign ram_wr_ena = (gnt0_s | gnt1_s) & we_s;
    assign ram_rd_ena = (gnt0_s | gnt1_s) & ~we_s;

    // Arbitration state, read-response tracking and saturating contention counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_r        <= 1'b0;
            last_r         <= 1'b1;
            rd_pend_r      <= 1'b0;
            rd_port_r      <= 1'b0;
            conflict_cnt_r <= {CNT_WIDTH{1'b0}};
        end else begin
            ready_r   <= 1'b1;
            rd_pend_r <= ram_rd_ena;
            rd_port_r <= gnt1_s;
            if (gnt0_s) begin
                last_r <= 1'b0;
            end else if (gnt1_s) begin
                last_r <= 1'b1;
            end else begin
                last_r <= last_r;
            end
            if (ready_r && both_req_s && (conflict_cnt_r != {CNT_WIDTH{1'b1}})) begin
                conflict_cnt_r <= conflict_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                conflict_cnt_r <= conflict_cnt_r;
            end
        end
    end

    assign conflict_cnt = conflict_cnt_r;
    assign m0_rvalid    = rd_pend_r & ~rd_port_r;
    assign m1_rvalid    = rd_pend_r & rd_port_r;

    // Read data is only passed through to the port that owns the response.
    always_comb begin
        if (m0_rvalid) begin
            m0_rdata = ram_rd_data;
        end else begin
            m0_rdata = {DATA_WIDTH{1'b0}};
        end
        if (m1_rvalid) begin
            m1_rdata = ram_rd_data;
        end else begin
            m1_rdata = {DATA_WIDTH{1'b0}};
        end
    end

endmodule
